// File: rtl/cell_seq_pkg.sv
// Shared definitions for the 2-input cell test sequencer.
package cell_seq_pkg;

    localparam int VEC_COUNT = 4;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Down-counter holding the sequencer in SETTLE for exactly CYC cycles.
module settle_timer #(
    parameter int CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int W = (CYC > 1) ? $clog2(CYC) : 1;
    // Loaded with CYC-1 so that expiry lands on the CYC-th enabled cycle.
    localparam logic [W-1:0] LOAD_VAL = W'((CYC > 0) ? CYC - 1 : 0);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= LOAD_VAL;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - ONE;
    end

    assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/cell_test_sequencer.sv
// Sweeps all four {a,b} vectors through a 2-input cell NUM_PASSES times
// and records mismatches against a latched truth table.
module cell_test_sequencer
    import cell_seq_pkg::*;
#(
    parameter int SETTLE_CYC = 3,
    parameter int NUM_PASSES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       truth_tbl,
    input  logic             y_i,
    output logic             a_o,
    output logic             b_o,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [3:0]       fail_vec,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PW = $clog2(NUM_PASSES + 1);
    localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);
    localparam logic [PW-1:0]    PASS_ONE = PW'(1);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_idx;
    logic [PW-1:0]    r_pass;
    logic [3:0]       r_tbl;
    logic             r_fail;
    logic [3:0]       r_fail_vec;
    logic [CNT_W-1:0] r_err;

    logic w_expire;
    logic w_load;
    logic w_settling;
    logic w_last_vec;
    logic w_last_pass;
    logic w_mismatch;

    assign w_load      = (r_state == APPLY);
    assign w_settling  = (r_state == SETTLE);
    assign w_last_vec  = (r_idx == 2'(VEC_COUNT - 1));
    assign w_last_pass = (r_pass == PW'(NUM_PASSES - 1));
    assign w_mismatch  = (y_i != r_tbl[r_idx]);

    settle_timer #(.CYC(SETTLE_CYC)) u_settle (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_en     (w_settling),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = APPLY;
            APPLY:   w_next = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
            SETTLE:  if (w_expire) w_next = SAMPLE;
            SAMPLE:  w_next = (w_last_vec && w_last_pass) ? DONE : APPLY;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Result registers persist through IDLE; only an accepted start clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_pass     <= '0;
            r_tbl      <= '0;
            r_fail     <= 1'b0;
            r_fail_vec <= '0;
            r_err      <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_tbl      <= truth_tbl;
                    r_idx      <= '0;
                    r_pass     <= '0;
                    r_fail     <= 1'b0;
                    r_fail_vec <= '0;
                    r_err      <= '0;
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        r_fail            <= 1'b1;
                        r_fail_vec[r_idx] <= 1'b1;
                        if (r_err != '1)
                            r_err <= r_err + ERR_ONE;
                    end
                    r_idx <= r_idx + 2'd1;
                    if (w_last_vec)
                        r_pass <= w_last_pass ? '0 : r_pass + PASS_ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy     = (r_state == APPLY) || (r_state == SETTLE) || (r_state == SAMPLE);
        done     = (r_state == DONE);
        a_o      = busy & r_idx[1];
        b_o      = busy & r_idx[0];
        fail     = r_fail;
        fail_vec = r_fail_vec;
        err_cnt  = r_err;
    end

endmodule
